// File: rtl/gci_std_fifo_stream_reader.sv
// Read-side drain engine: pops a show-ahead FIFO into a 2-entry registered buffer
// and presents words with valid/ready; the FIFO pop never depends on iREADY.
//  state | meaning
//  EMPTY | buffer holds no word, oVALID low
//  ONE   | head register holds the next word to deliver
//  TWO   | head and skid both full, FIFO pop stalled
module gci_std_fifo_stream_reader #(
  parameter int P_N     = 16,
  parameter int P_CNT_N = 16
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iREMOVE,
  output logic               oFIFO_RD_EN,
  input  logic [P_N-1:0]     iFIFO_RD_DATA,
  input  logic               iFIFO_RD_EMPTY,
  output logic               oVALID,
  output logic [P_N-1:0]     oDATA,
  input  logic               iREADY,
  output logic [P_CNT_N-1:0] oCOUNT,
  output logic               oBUSY
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t               occ;
  logic [P_N-1:0]     headData;
  logic [P_N-1:0]     skidData;
  logic [P_CNT_N-1:0] count;
  logic               push;
  logic               take;

  // Pop decision uses only registered occupancy and FIFO flags.
  assign oFIFO_RD_EN = inRESET && !iREMOVE && !iFIFO_RD_EMPTY && (occ != TWO);
  assign push        = oFIFO_RD_EN;
  assign take        = oVALID && iREADY;

  assign oVALID = (occ != EMPTY);
  assign oBUSY  = (occ != EMPTY);
  assign oDATA  = headData;
  assign oCOUNT = count;

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      occ      <= EMPTY;
      headData <= '0;
      skidData <= '0;
      count    <= '0;
    end else if (iREMOVE) begin
      occ   <= EMPTY;
      count <= '0;
    end else begin
      if (take) begin
        count <= count + {{(P_CNT_N-1){1'b0}}, 1'b1};
      end
      case (occ)
        EMPTY: begin
          if (push) begin
            headData <= iFIFO_RD_DATA;
            occ      <= ONE;
          end
        end
        ONE: begin
          case ({push, take})
            2'b10: begin
              skidData <= iFIFO_RD_DATA;
              occ      <= TWO;
            end
            2'b01: occ <= EMPTY;
            2'b11: headData <= iFIFO_RD_DATA;
            default: occ <= ONE;
          endcase
        end
        TWO: begin
          if (take) begin
            headData <= skidData;
            occ      <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_gci_std_fifo_stream_reader.sv
// Bench for gci_std_fifo_stream_reader: a queue-based FIFO and buffer model
// predicts every output; a second instance with a 4-bit counter covers wrap.
module tb_gci_std_fifo_stream_reader;

  logic        iCLOCK;
  logic        inRESET;
  logic        iREMOVE;
  logic        oFIFO_RD_EN;
  logic [15:0] iFIFO_RD_DATA;
  logic        iFIFO_RD_EMPTY;
  logic        oVALID;
  logic [15:0] oDATA;
  logic        iREADY;
  logic [15:0] oCOUNT;
  logic        oBUSY;

  logic        wRdEn;
  logic        wValid;
  logic [15:0] wData;
  logic [3:0]  wCount;
  logic        wBusy;

  gci_std_fifo_stream_reader #(.P_N(16), .P_CNT_N(16)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(iREMOVE),
    .oFIFO_RD_EN(oFIFO_RD_EN), .iFIFO_RD_DATA(iFIFO_RD_DATA),
    .iFIFO_RD_EMPTY(iFIFO_RD_EMPTY), .oVALID(oVALID), .oDATA(oDATA),
    .iREADY(iREADY), .oCOUNT(oCOUNT), .oBUSY(oBUSY)
  );

  gci_std_fifo_stream_reader #(.P_N(16), .P_CNT_N(4)) dutW (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(iREMOVE),
    .oFIFO_RD_EN(wRdEn), .iFIFO_RD_DATA(iFIFO_RD_DATA),
    .iFIFO_RD_EMPTY(iFIFO_RD_EMPTY), .oVALID(wValid), .oDATA(wData),
    .iREADY(iREADY), .oCOUNT(wCount), .oBUSY(wBusy)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  int checks = 0;
  int errors = 0;

  logic [15:0] fifoQ[$];
  logic [15:0] mBuf[$];
  logic [15:0] tookQ[$];
  int          mCount = 0;
  logic        lastRd;

  typedef struct {
    logic        nrst;
    logic        rem;
    logic        rdy;
    int          nLoad;
    logic [15:0] base;
    logic        expRd;
    logic        expValid;
    logic        chkData;
    logic [15:0] expData;
    int          expCount;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fifoQ.push_back(base + 16'(i));
  endtask

  // One clock: drive, check pop decision, clock, advance model, check outputs.
  task automatic step(input logic nrst, input logic rem, input logic rdy);
    logic        expRd;
    logic        mTake;
    logic [15:0] takenData;
    inRESET        = nrst;
    iREMOVE        = rem;
    iREADY         = rdy;
    iFIFO_RD_EMPTY = (fifoQ.size() == 0);
    iFIFO_RD_DATA  = (fifoQ.size() != 0) ? fifoQ[0] : 16'hDEAD;
    #1;
    expRd = nrst && !rem && (fifoQ.size() != 0) && (mBuf.size() < 2);
    mTake = nrst && !rem && (mBuf.size() != 0) && rdy;
    check("rd_en", 32'(oFIFO_RD_EN), 32'(expRd));
    check("w_rd_en", 32'(wRdEn), 32'(expRd));
    lastRd    = oFIFO_RD_EN;
    takenData = oDATA;
    @(posedge iCLOCK);
    #1;
    if (!nrst) begin
      mBuf.delete();
      mCount = 0;
    end else if (rem) begin
      mBuf.delete();
      fifoQ.delete();
      mCount = 0;
    end else begin
      if (mTake) begin
        void'(mBuf.pop_front());
        tookQ.push_back(takenData);
        mCount++;
      end
      if (expRd) mBuf.push_back(fifoQ.pop_front());
    end
    check("valid", 32'(oVALID), 32'(mBuf.size() != 0));
    check("busy", 32'(oBUSY), 32'(mBuf.size() != 0));
    check("w_valid", 32'(wValid && wBusy), 32'(mBuf.size() != 0));
    if (mBuf.size() != 0) begin
      check("data", 32'(oDATA), 32'(mBuf[0]));
      check("w_data", 32'(wData), 32'(mBuf[0]));
    end else if (!nrst) begin
      check("rst_data", 32'(oDATA), 32'h0);
    end
    check("count", 32'(oCOUNT), 32'(mCount % 65536));
    check("w_count", 32'(wCount), 32'(mCount % 16));
  endtask

  initial begin
    int pops;
    int gap;
    int sent;
    int mism;
    inRESET = 1'b0; iREMOVE = 1'b0; iREADY = 1'b0;
    iFIFO_RD_EMPTY = 1'b1; iFIFO_RD_DATA = '0;

    // Reset, then stream four preloaded words.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4, 16'h1, 1'b1, 1'b1, 1'b1, 16'h1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h2, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h3, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h4, 3};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 4};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 4};
    for (int v = 0; v < 8; v++) begin
      load(vecs[v].nLoad, vecs[v].base);
      step(vecs[v].nrst, vecs[v].rem, vecs[v].rdy);
      check("vec_rd", 32'(lastRd), 32'(vecs[v].expRd));
      check("vec_valid", 32'(oVALID), 32'(vecs[v].expValid));
      if (vecs[v].chkData) check("vec_data", 32'(oDATA), 32'(vecs[v].expData));
      check("vec_count", 32'(oCOUNT), 32'(vecs[v].expCount));
    end

    // Backpressure: two pops then stall, head stable, in-order drain without gaps.
    step(1'b1, 1'b1, 1'b1);
    load(8, 16'hA0);
    pops = 0;
    step(1'b1, 1'b0, 1'b0);
    pops += int'(lastRd);
    check("bp_first_valid", 32'(oVALID), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      pops += int'(lastRd);
      check("bp_hold_data", 32'(oDATA), 32'hA0);
    end
    check("bp_pops", 32'(pops), 32'd2);
    check("bp_rd_low", 32'(lastRd), 32'h0);
    tookQ.delete();
    gap = 0;
    for (int i = 0; i < 20 && tookQ.size() < 8; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (tookQ.size() < 8 && !oVALID) gap++;
    end
    check("bp_gap", 32'(gap), 32'd0);
    check("bp_len", 32'(tookQ.size()), 32'd8);
    for (int i = 0; i < tookQ.size(); i++) check("bp_order", 32'(tookQ[i]), 32'(16'hA0 + 16'(i)));

    // Empty gap between two single words.
    step(1'b1, 1'b1, 1'b1);
    load(1, 16'h11);
    step(1'b1, 1'b0, 1'b1);
    check("gap_v11", 32'({oVALID, oDATA}), 32'h1_0011);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check("gap_low", 32'(oVALID), 32'h0);
    end
    load(1, 16'h22);
    step(1'b1, 1'b0, 1'b1);
    check("gap_v22", 32'({oVALID, oDATA}), 32'h1_0022);
    step(1'b1, 1'b0, 1'b1);
    check("gap_end", 32'(oVALID), 32'h0);
    check("gap_count", 32'(oCOUNT), 32'd2);

    // Random feed and random iREADY, 1000 incrementing words.
    step(1'b1, 1'b1, 1'b1);
    tookQ.delete();
    sent = 0;
    for (int c = 0; c < 6000 && tookQ.size() < 1000; c++) begin
      if (sent < 1000 && fifoQ.size() < 8 && $urandom_range(0, 3) != 0) begin
        fifoQ.push_back(16'(sent));
        sent++;
      end
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
    check("rand_len", 32'(tookQ.size()), 32'd1000);
    mism = 0;
    for (int i = 0; i < tookQ.size(); i++) if (tookQ[i] !== 16'(i)) mism++;
    check("rand_order", 32'(mism), 32'd0);
    check("rand_count", 32'(oCOUNT), 32'd1000);

    // Flush with a full buffer and a non-empty FIFO, then resume.
    load(3, 16'h70);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("flush_pre_busy", 32'(oBUSY), 32'h1);
    step(1'b1, 1'b1, 1'b1);
    check("flush_rd", 32'(lastRd), 32'h0);
    check("flush_valid", 32'(oVALID), 32'h0);
    check("flush_count", 32'(oCOUNT), 32'h0);
    load(1, 16'h55);
    step(1'b1, 1'b0, 1'b1);
    check("flush_resume", 32'({oVALID, oDATA}), 32'h1_0055);
    step(1'b1, 1'b0, 1'b1);
    check("flush_resume_count", 32'(oCOUNT), 32'd1);

    // Counter wrap on the 4-bit instance: 15 -> 0 -> 1.
    step(1'b1, 1'b1, 1'b1);
    load(17, 16'h200);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (mCount == 15) check("wrap_15", 32'(wCount), 32'd15);
      if (mCount == 16) check("wrap_0", 32'(wCount), 32'd0);
    end
    check("wrap_1", 32'(wCount), 32'd1);
    check("wrap_wide", 32'(oCOUNT), 32'd17);

    // Reset in the middle of traffic clears everything.
    load(2, 16'h300);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("mid_reset", 32'({oVALID, oBUSY, oDATA, oCOUNT}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
